axil_reg_slave: RTL and testbench

- AXI4-Lite responder: the bus target that consumes the AW/W/WSTRB beats produced by the bridge's initiator side, and answers AR reads.
- Holds a bank of 32-bit registers and applies byte-lane merges exactly per WSTRB.
- Sits behind the UART-AXI4 bridge master as its local register target (control/status/loopback registers).
- Independent write and read state machines with full valid/ready handshakes on all five channels.

---
 rtl/axil_reg_slave.sv | 150 +++++++++++++++
 tb/tb_axil_reg_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_slave.sv
// axil_reg_slave: AXI4-Lite register bank target with byte-lane writes and address decode.
// Optional build macro AXIL_REG_STRICT_STRB_EN: a hit write with wstrb==0 answers SLVERR instead of OKAY.
module axil_reg_slave #(
    parameter int          NUM_REGS    = 16,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   reg_q,
    output logic [NUM_REGS-1:0]      wr_pulse
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t    w_state, w_next;
    r_state_t    r_state, r_next;
    logic [31:0] regs [NUM_REGS];
    logic [31:0] aw_q, w_q, c_addr, c_data, w_off, r_off, r_sel;
    logic [3:0]  strb_q, c_strb;
    logic [1:0]  c_resp;
    logic        commit, w_hit, r_hit, w_en, zero_err;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[32*i +: 32] = regs[i];
    end

    // Write channel sequencing: readies from state only, commit operands muxed from live bus or latches
    always_comb begin
        w_next        = w_state;
        commit        = 1'b0;
        c_addr        = s_axi_awaddr;
        c_data        = s_axi_wdata;
        c_strb        = s_axi_wstrb;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                commit        = s_axi_awvalid && s_axi_wvalid;
                w_next        = commit ? W_RESP : s_axi_awvalid ? W_HAVE_AW : s_axi_wvalid ? W_HAVE_W : W_IDLE;
            end
            W_HAVE_AW: begin
                s_axi_wready = 1'b1;
                c_addr       = aw_q;
                commit       = s_axi_wvalid;
                w_next       = s_axi_wvalid ? W_RESP : W_HAVE_AW;
            end
            W_HAVE_W: begin
                s_axi_awready = 1'b1;
                c_data        = w_q;
                c_strb        = strb_q;
                commit        = s_axi_awvalid;
                w_next        = s_axi_awvalid ? W_RESP : W_HAVE_W;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                w_next       = s_axi_bready ? W_IDLE : W_RESP;
            end
            default: w_next = W_IDLE;
        endcase
    end

`ifdef AXIL_REG_STRICT_STRB_EN
    assign zero_err = (c_strb == 4'b0000);
`else
    assign zero_err = 1'b0;
`endif

    assign w_off  = c_addr - BASE_ADDR;
    assign w_hit  = w_off[31:2] < 30'(NUM_REGS);
    assign w_en   = commit && w_hit && (c_strb != 4'b0000);
    assign c_resp = !w_hit ? 2'b11 : zero_err ? 2'b10 : 2'b00;

    // Write state, operand latches, response code and byte-lane register updates
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state     <= W_IDLE;
            aw_q        <= '0;
            w_q         <= '0;
            strb_q      <= '0;
            s_axi_bresp <= 2'b00;
            wr_pulse    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
        end else begin
            w_state <= w_next;
            if (w_state == W_IDLE && s_axi_awvalid) aw_q <= s_axi_awaddr;
            if (w_state == W_IDLE && s_axi_wvalid) begin
                w_q    <= s_axi_wdata;
                strb_q <= s_axi_wstrb;
            end
            if (commit) s_axi_bresp <= c_resp;
            for (int i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= w_en && (w_off[31:2] == 30'(i));
                for (int n = 0; n < 4; n++)
                    if (w_en && (w_off[31:2] == 30'(i)) && c_strb[n]) regs[i][8*n +: 8] <= c_data[8*n +: 8];
            end
        end
    end

    assign r_off = s_axi_araddr - BASE_ADDR;
    assign r_hit = r_off[31:2] < 30'(NUM_REGS);

    // Read mux; an out-of-range index matches no register and yields zero
    always_comb begin
        r_sel = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (r_off[31:2] == 30'(i)) r_sel = regs[i];
    end

    // Read channel sequencing from state only
    always_comb begin
        s_axi_arready = (r_state == R_IDLE);
        s_axi_rvalid  = (r_state == R_DATA);
        r_next        = (r_state == R_IDLE) ? (s_axi_arvalid ? R_DATA : R_IDLE) : (s_axi_rready ? R_IDLE : R_DATA);
    end

    // Read state and captured data/response, held until rready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= R_IDLE;
            s_axi_rdata <= '0;
            s_axi_rresp <= 2'b00;
        end else begin
            r_state <= r_next;
            if (r_state == R_IDLE && s_axi_arvalid) begin
                s_axi_rdata <= r_sel;
                s_axi_rresp <= r_hit ? 2'b00 : 2'b11;
            end
        end
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// tb_axil_reg_slave: randomized self-checking bench for axil_reg_slave against an array model.
module tb_axil_reg_slave;
    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef AXIL_REG_STRICT_STRB_EN
    localparam logic [1:0] ZERO_RESP = 2'b10;
`else
    localparam logic [1:0] ZERO_RESP = 2'b00;
`endif

    logic         clk = 1'b0, rst = 1'b1;
    logic [31:0]  awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]   wstrb = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] reg_q;
    logic [15:0]  wr_pulse;

    logic [31:0]  model [16];
    int           tests = 0, fails = 0;
    bit           timeout_hit = 1'b0;

    axil_reg_slave dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return off[31:2] < 30'd16;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[5:2]);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [3:0] s);
        if (!is_hit(a)) return 2'b11;
        return (s == 4'b0000) ? ZERO_RESP : 2'b00;
    endfunction

    function automatic logic [15:0] exp_pulse(input logic [31:0] a, input logic [3:0] s);
        logic [15:0] p;
        p = '0;
        if (is_hit(a) && s != 4'b0000) p[idx_of(a)] = 1'b1;
        return p;
    endfunction

    function automatic void model_write(input logic [31:0] a, d, input logic [3:0] s);
        if (is_hit(a))
            for (int n = 0; n < 4; n++)
                if (s[n]) model[idx_of(a)][8*n +: 8] = d[8*n +: 8];
    endfunction

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input int da, dw, bd,
                            output logic [1:0] resp, output logic [15:0] p0, p1, output bit stable);
        int cyc = 0, k = 0;
        bit aw_done = 0, w_done = 0, haw, hw, hb;
        stable = 1;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= da;
            wvalid  = !w_done && cyc >= dw;
            haw = awvalid && awready;
            hw  = wvalid && wready;
            step();
            aw_done |= haw; w_done |= hw; cyc++;
        end
        awvalid = 0; wvalid = 0;
        if (!(aw_done && w_done)) timeout_hit = 1;
        p0 = wr_pulse; resp = bresp; p1 = '1;
        while (k < 60) begin
            if (!bvalid) begin timeout_hit = 1; break; end
            if (k < bd) stable &= (bresp === resp) && !awready && !wready;
            bready = (k >= bd);
            hb = bready;
            step();
            if (k == 0) p1 = wr_pulse;
            k++;
            if (hb) break;
        end
        bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int rd, output logic [31:0] data,
                           output logic [1:0] resp, output bit lat, stable);
        int cyc = 0;
        bit h = 0;
        stable = 1; araddr = a; arvalid = 1;
        while (!h && cyc < 50) begin
            h = arready;
            step();
            cyc++;
        end
        arvalid = 0;
        if (!h) timeout_hit = 1;
        lat = rvalid; data = rdata; resp = rresp;
        for (int k = 0; k < rd; k++) begin
            stable &= rvalid && (rdata === data) && (rresp === resp) && !arready;
            step();
        end
        rready = 1;
        step();
        rready = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit lat, st;
        rst = 1;
        repeat (3) step();
        rst = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        tests++;
        if (reg_q !== model_flat()) begin fails++; $display("FAIL reset_regs got %h exp %h", reg_q, model_flat()); end
        tests++;
        if ({bvalid, rvalid, wr_pulse} !== 18'h0) begin fails++; $display("FAIL reset_valids got %b/%b/%h exp 0", bvalid, rvalid, wr_pulse); end
        tests++;
        if ({awready, wready, arready, bresp, rresp, rdata} !== {3'b111, 36'h0}) begin
            fails++; $display("FAIL reset_idle got aw%b w%b ar%b b%b r%b d%h exp 111/0", awready, wready, arready, bresp, rresp, rdata);
        end
        do_read(BASE + 32'h8, 0, d, r, lat, st);
        tests++;
        if ({lat, r, d} !== {1'b1, 2'b00, 32'h0}) begin fails++; $display("FAIL reset_read got lat%b resp%b data%h exp 1/00/0", lat, r, d); end
    endtask

    task automatic test_full_write();
        logic [1:0] r; logic [15:0] p0, p1; bit st;
        do_write(32'h100C, 32'hAABBCCDD, 4'hF, 0, 0, 0, r, p0, p1, st);
        model_write(32'h100C, 32'hAABBCCDD, 4'hF);
        tests++;
        if (r !== 2'b00) begin fails++; $display("FAIL full_write_bresp got %b exp 00", r); end
        tests++;
        if (reg_q[3*32 +: 32] !== 32'hAABBCCDD) begin fails++; $display("FAIL full_write_reg got %h exp aabbccdd", reg_q[3*32 +: 32]); end
        tests++;
        if ({p0, p1} !== {16'h0008, 16'h0000}) begin fails++; $display("FAIL full_write_pulse got %h,%h exp 0008,0000", p0, p1); end
    endtask

    task automatic test_w_first();
        logic [15:0] p;
        awaddr = 32'h100C; wdata = 32'h11223344; wstrb = 4'b0100; wvalid = 1;
        step();
        wvalid = 0;
        tests++;
        if ({wready, awready} !== 2'b01) begin fails++; $display("FAIL w_first_ready got w%b aw%b exp w0 aw1", wready, awready); end
        step(); step();
        awvalid = 1;
        step();
        awvalid = 0;
        p = wr_pulse;
        model_write(32'h100C, 32'h11223344, 4'b0100);
        tests++;
        if ({bvalid, bresp, p} !== {1'b1, 2'b00, 16'h0008}) begin fails++; $display("FAIL w_first_resp got v%b r%b p%h exp 1/00/0008", bvalid, bresp, p); end
        tests++;
        if (reg_q[3*32 +: 32] !== 32'hAA22CCDD) begin fails++; $display("FAIL w_first_reg got %h exp aa22ccdd", reg_q[3*32 +: 32]); end
        bready = 1;
        step();
        bready = 0;
    endtask

    task automatic test_decerr();
        logic [1:0] r; logic [15:0] p0, p1; logic [31:0] d; bit st, lat;
        do_write(32'h1040, 32'hFFFFFFFF, 4'hF, 0, 0, 0, r, p0, p1, st);
        tests++;
        if ({r, p0} !== {2'b11, 16'h0}) begin fails++; $display("FAIL decerr_write got %b/%h exp 11/0000", r, p0); end
        tests++;
        if (reg_q !== model_flat()) begin fails++; $display("FAIL decerr_regs got %h exp %h", reg_q, model_flat()); end
        do_read(32'h0FFC, 0, d, r, lat, st);
        tests++;
        if ({r, d} !== {2'b11, 32'h0}) begin fails++; $display("FAIL decerr_read got %b/%h exp 11/0", r, d); end
    endtask

    task automatic test_backpressure();
        logic [1:0] r; logic [15:0] p0, p1; logic [31:0] d; bit st, lat;
        do_write(32'h1004, 32'h5A5A1234, 4'hF, 0, 0, 5, r, p0, p1, st);
        model_write(32'h1004, 32'h5A5A1234, 4'hF);
        tests++;
        if ({st, r} !== 3'b100) begin fails++; $display("FAIL bp_write got stable%b resp%b exp 1/00", st, r); end
        do_read(32'h1004, 5, d, r, lat, st);
        tests++;
        if ({st, lat, d} !== {2'b11, model[1]}) begin fails++; $display("FAIL bp_read got stable%b lat%b %h exp 1/1/%h", st, lat, d, model[1]); end
    endtask

    task automatic test_zero_strb();
        logic [1:0] r; logic [15:0] p0, p1; bit st;
        do_write(32'h1000, 32'hFFFFFFFF, 4'h0, 0, 0, 0, r, p0, p1, st);
        tests++;
        if ({r, p0, p1} !== {ZERO_RESP, 32'h0}) begin fails++; $display("FAIL zero_strb got %b/%h/%h exp %b/0/0", r, p0, p1, ZERO_RESP); end
        tests++;
        if (reg_q[31:0] !== model[0]) begin fails++; $display("FAIL zero_strb_reg got %h exp %h", reg_q[31:0], model[0]); end
    endtask

    task automatic test_simultaneous();
        logic [31:0] old;
        old = model[5];
        awaddr = 32'h1014; wdata = 32'hDEADBEEF; wstrb = 4'hF; araddr = 32'h1014;
        awvalid = 1; wvalid = 1; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        model_write(32'h1014, 32'hDEADBEEF, 4'hF);
        tests++;
        if ({rvalid, rdata} !== {1'b1, old}) begin fails++; $display("FAIL simul_read got %b/%h exp 1/%h", rvalid, rdata, old); end
        tests++;
        if ({bvalid, reg_q[5*32 +: 32]} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL simul_write got %b/%h exp 1/deadbeef", bvalid, reg_q[5*32 +: 32]); end
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r; logic [15:0] p0, p1; bit st, lat;
        int i;
        for (int t = 0; t < 40; t++) begin
            i = int'($urandom_range(0, 19));
            a = (i == 19) ? BASE - 32'(4 * $urandom_range(1, 4)) : BASE + 32'(4 * i) + 32'($urandom_range(0, 3));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), r, p0, p1, st);
            model_write(a, d, s);
            tests++;
            if ({r, p0, p1} !== {exp_resp(a, s), exp_pulse(a, s), 16'h0}) begin
                fails++; $display("FAIL rand_write a=%h s=%b got %b/%h/%h exp %b/%h/0", a, s, r, p0, p1, exp_resp(a, s), exp_pulse(a, s));
            end
            a = BASE + 32'(4 * $urandom_range(0, 17));
            do_read(a, int'($urandom_range(0, 2)), rd, r, lat, st);
            tests++;
            if ({lat, r, rd} !== {1'b1, is_hit(a) ? 2'b00 : 2'b11, is_hit(a) ? model[idx_of(a)] : 32'h0}) begin
                fails++; $display("FAIL rand_read a=%h got %b/%b/%h", a, lat, r, rd);
            end
        end
        tests++;
        if (reg_q !== model_flat()) begin fails++; $display("FAIL rand_final got %h exp %h", reg_q, model_flat()); end
    endtask

    initial begin
        test_reset();
        test_full_write();
        test_w_first();
        test_decerr();
        test_backpressure();
        test_zero_strb();
        test_simultaneous();
        test_random();
        tests++;
        if (timeout_hit) begin fails++; $display("FAIL handshake_timeout got expired exp none"); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
